// File: rtl/majority_vote_arbiter_pkg.sv
// Shared definitions for the majority-vote arbiter: FSM encodings, vote width
// and the round-robin selection helper.
package majority_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_VOTE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int VOTE_W = 3;

  // Returns the first set bit of valid, scanning from last+1 modulo nreq.
  // Only the low nreq bits are considered; nreq is at most 16.
  function automatic logic [3:0] rr_pick(input logic [15:0] valid,
                                         input logic [3:0]  last,
                                         input logic [4:0]  nreq);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= 16; k++) begin
      idx = (int'(last) + k) % int'(nreq);
      if (!found && (k <= int'(nreq)) && valid[idx]) begin
        pick  = 4'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/majority_vote_arbiter_if.sv
// Request/result bus between the redundant-channel samplers, the arbiter and
// the downstream consumer.
interface majority_vote_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_votes;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic              res_vote;
  logic              res_unanimous;

  // Requesters and consumer side
  modport master (
    output req_valid, req_votes, res_ready,
    input  req_ready, res_valid, res_id, res_vote, res_unanimous
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_votes, res_ready,
    output req_ready, res_valid, res_id, res_vote, res_unanimous
  );
endinterface

// File: rtl/majority_vote_arbiter_majority_1.sv
// Combinational 2-of-3 majority voter shared by all requesters.
module majority_1 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f
);
  assign f = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/majority_vote_arbiter.sv
// Round-robin arbiter that time-shares one majority voter among NREQ
// requesters, returns the vote with the requester id and counts
// non-unanimous votes.
module majority_vote_arbiter
  import majority_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CNTW = 8,
  parameter int IDW  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  majority_vote_arbiter_if.slave  bus,
  input  logic                    dis_clr,
  output logic [CNTW-1:0]         dis_count,
  output logic                    busy
);

  logic [1:0]        state_r;
  logic [IDW-1:0]    last_grant_r;
  logic [IDW-1:0]    cap_id_r;
  logic [VOTE_W-1:0] cap_votes_r;
  logic              res_valid_r;
  logic [IDW-1:0]    res_id_r;
  logic              res_vote_r;
  logic              res_unan_r;
  logic [CNTW-1:0]   dis_count_r;

  logic [15:0]       valid_ext_s;
  logic [3:0]        pick_s;
  logic [IDW-1:0]    grant_s;
  logic [VOTE_W-1:0] grant_votes_s;
  logic              any_valid_s;
  logic [NREQ-1:0]   ready_s;
  logic              maj_s;
  logic              unan_s;

  // Round-robin choice among valid requesters, starting after the last grant
  always_comb begin
    valid_ext_s             = 16'h0000;
    valid_ext_s[NREQ-1:0]   = bus.req_valid;
    any_valid_s             = |bus.req_valid;
    pick_s                  = rr_pick(valid_ext_s, 4'(last_grant_r), 5'(NREQ));
    grant_s                 = IDW'(pick_s);
  end

  // Select the vote triplet of the granted requester
  always_comb begin
    grant_votes_s = {VOTE_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s == IDW'(i)) begin
        grant_votes_s = bus.req_votes[VOTE_W*i +: VOTE_W];
      end else begin
        grant_votes_s = grant_votes_s;
      end
    end
  end

  // One-hot acceptance pulse; only offered in IDLE and never while in reset
  always_comb begin
    if (rst_n && (state_r == ST_IDLE) && any_valid_s) begin
      ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
    end else begin
      ready_s = {NREQ{1'b0}};
    end
  end

  majority_1 u_voter (
    .a (cap_votes_r[2]),
    .b (cap_votes_r[1]),
    .c (cap_votes_r[0]),
    .f (maj_s)
  );

  assign unan_s = (cap_votes_r == 3'b000) || (cap_votes_r == 3'b111);

  // Control FSM with capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDW'(NREQ - 1);
      cap_id_r     <= {IDW{1'b0}};
      cap_votes_r  <= {VOTE_W{1'b0}};
      res_valid_r  <= 1'b0;
      res_id_r     <= {IDW{1'b0}};
      res_vote_r   <= 1'b0;
      res_unan_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            cap_votes_r  <= grant_votes_s;
            cap_id_r     <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= ST_VOTE;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_VOTE: begin
          res_vote_r  <= maj_s;
          res_unan_r  <= unan_s;
          res_id_r    <= cap_id_r;
          res_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_HOLD;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating disagreement counter; a clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dis_count_r <= {CNTW{1'b0}};
    end else if (dis_clr) begin
      dis_count_r <= {CNTW{1'b0}};
    end else if ((state_r == ST_VOTE) && !unan_s && (dis_count_r != {CNTW{1'b1}})) begin
      dis_count_r <= dis_count_r + CNTW'(1);
    end else begin
      dis_count_r <= dis_count_r;
    end
  end

  assign bus.req_ready     = ready_s;
  assign bus.res_valid     = res_valid_r;
  assign bus.res_id        = res_id_r;
  assign bus.res_vote      = res_vote_r;
  assign bus.res_unanimous = res_unan_r;
  assign dis_count         = dis_count_r;
  assign busy              = (state_r != ST_IDLE);

endmodule

// File: tb/tb_majority_vote_arbiter.sv
// Self-checking bench for majority_vote_arbiter: directed scenarios followed
// by random traffic, all compared against a transaction-level reference model.
module tb_majority_vote_arbiter;

  localparam int NREQ = 4;
  localparam int CNTW = 2;
  localparam int IDW  = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dis_clr;
  logic [CNTW-1:0] dis_count;
  logic            busy;

  majority_vote_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  majority_vote_arbiter #(.NREQ(NREQ), .CNTW(CNTW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dis_clr   (dis_clr),
    .dis_count (dis_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus applied each cycle
  logic [NREQ-1:0]   s_valid;
  logic [3*NREQ-1:0] s_votes;
  bit                s_rready;
  bit                s_clr;
  bit                s_rst;

  // reference model: transaction state
  int   cyc = 0;
  int   m_last;
  bit   m_idle;
  bit   m_rv;
  int   m_id;
  bit   m_vote;
  bit   m_unan;
  int   m_cnt;
  bit   p_valid;
  int   p_due;
  int   p_id;
  logic [2:0] p_votes;
  int   last_gnt = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int ones3(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  task automatic model_reset();
    m_last = NREQ - 1; m_idle = 1'b1; m_rv = 1'b0;
    m_id = 0; m_vote = 1'b0; m_unan = 1'b0; m_cnt = 0;
    p_valid = 1'b0; last_gnt = -1;
  endtask

  // one clock: drive after the edge, compare at the falling edge, advance model
  task automatic cycle();
    int  g;
    int  n;
    bit  nx_idle;
    bit  nx_rv;
    logic [NREQ-1:0] exp_ready;
    @(posedge clk); #1;
    rst_n         = s_rst;
    bus.req_valid = s_valid;
    bus.req_votes = s_votes;
    bus.res_ready = s_rready;
    dis_clr       = s_clr;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_dis_count", dis_count, 0);
      chk("rst_busy", busy, 0);
    end else begin
      g = m_idle ? rr(s_valid, m_last) : -1;
      exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
      chk("req_ready", bus.req_ready, exp_ready);
      chk("res_valid", bus.res_valid, m_rv);
      chk("res_id", bus.res_id, m_id);
      chk("res_vote", bus.res_vote, m_vote);
      chk("res_unanimous", bus.res_unanimous, m_unan);
      chk("dis_count", dis_count, m_cnt);
      chk("busy", busy, !m_idle);
      last_gnt = g;
      nx_idle = m_idle;
      nx_rv   = m_rv;
      if (p_valid && (p_due == cyc + 1)) begin
        n      = ones3(p_votes);
        m_vote = (n >= 2);
        m_unan = (n == 0) || (n == 3);
        m_id   = p_id;
        nx_rv  = 1'b1;
        p_valid = 1'b0;
        if (!m_unan && m_cnt < CMAX) m_cnt++;
      end
      if (g >= 0) begin
        nx_idle = 1'b0;
        m_last  = g;
        p_valid = 1'b1;
        p_due   = cyc + 2;
        p_id    = g;
        p_votes = s_votes[3*g +: 3];
      end
      if (m_rv && s_rready) begin
        nx_rv   = 1'b0;
        nx_idle = 1'b1;
      end
      if (s_clr) m_cnt = 0;
      m_idle = nx_idle;
      m_rv   = nx_rv;
    end
  endtask

  // single transaction: grant, vote (optional clear), hold with consumer ready
  task automatic txn(input int id, input logic [2:0] v, input bit clr_in_vote);
    s_valid = NREQ'(1 << id);
    s_votes = '0;
    s_votes[3*id +: 3] = v;
    s_rready = 1'b1;
    cycle();
    s_valid = '0;
    s_clr = clr_in_vote;
    cycle();
    s_clr = 1'b0;
    cycle();
  endtask

  int   gq[$];
  int   gc[$];
  int   sat_exp[6] = '{1, 2, 3, 3, 3, 0};
  logic [IDW-1:0] hold_id;
  logic           hold_vote;

  initial begin
    model_reset();
    rst_n = 1'b0; s_rst = 1'b0;
    s_valid = NREQ'($urandom); s_votes = 12'($urandom);
    s_rready = 1'($urandom); s_clr = 1'($urandom);
    bus.req_valid = s_valid; bus.req_votes = s_votes;
    bus.res_ready = s_rready; dis_clr = s_clr;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      s_valid = NREQ'($urandom); s_votes = 12'($urandom);
      s_rready = 1'($urandom); s_clr = 1'($urandom);
      cycle();
    end
    s_rst = 1'b1; s_clr = 1'b0; s_valid = '0; s_rready = 1'b1;
    cycle();

    // fairness: all requesting, unanimous votes
    s_valid = 4'b1111; s_votes = 12'hFFF;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (bus.req_ready != '0) begin
        gq.push_back($clog2(int'(bus.req_ready)));
        gc.push_back(cyc);
      end
    end
    chk("fair_count", gq.size(), 5);
    for (int k = 0; k < gq.size(); k++) begin
      chk("fair_order", gq[k], k % NREQ);
      if (k > 0) chk("fair_spacing", gc[k] - gc[k-1], 3);
    end
    chk("fair_dis_count", dis_count, 0);
    s_valid = '0;
    cycle();

    // single request from requester 2, votes 011
    s_valid = 4'b0100; s_votes = 12'h0C0; s_rready = 1'b1;
    cycle();
    chk("single_grant", bus.req_ready, 4'b0100);
    s_valid = '0;
    cycle();
    chk("single_t1_valid", bus.res_valid, 0);
    cycle();
    chk("single_t2_valid", bus.res_valid, 1);
    chk("single_id", bus.res_id, 2);
    chk("single_vote", bus.res_vote, 1);
    chk("single_unan", bus.res_unanimous, 0);
    chk("single_dis", dis_count, 1);
    cycle();

    // backpressure: requester 0 in flight, requester 1 waiting
    s_valid = 4'b0001; s_votes = 12'h005;
    cycle();
    s_valid = 4'b0010; s_votes = 12'h030; s_rready = 1'b0;
    cycle();
    cycle();
    hold_id = bus.res_id; hold_vote = bus.res_vote;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_id_stable", bus.res_id, hold_id);
      chk("bp_vote_stable", bus.res_vote, hold_vote);
      chk("bp_no_ready", bus.req_ready, 0);
    end
    s_rready = 1'b1;
    cycle();
    cycle();
    chk("bp_valid_fell", bus.res_valid, 0);
    chk("bp_next_grant", bus.req_ready, 4'b0010);
    s_valid = '0;
    cycle(); cycle(); cycle();

    // saturation with a clear coinciding with the sixth increment
    s_clr = 1'b1;
    cycle();
    s_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      txn(i % NREQ, 3'b001, i == 5);
      chk("sat_count", dis_count, sat_exp[i]);
    end
    cycle();

    // reset while a result is held, then first grant restarts from 0
    s_valid = 4'b0010; s_votes = 12'h018; s_rready = 1'b1;
    cycle();
    s_valid = '0; s_rready = 1'b0;
    cycle();
    cycle();
    chk("mid_valid_before", bus.res_valid, 1);
    rst_n = 1'b0; s_rst = 1'b0;
    #1;
    chk("mid_async_valid", bus.res_valid, 0);
    chk("mid_async_busy", busy, 0);
    model_reset();
    cycle(); cycle();
    s_rst = 1'b1; s_valid = 4'b1001; s_votes = 12'hE07; s_rready = 1'b1;
    cycle();
    chk("mid_first_grant", bus.req_ready, 4'b0001);
    s_valid = '0;
    cycle(); cycle(); cycle();

    // random traffic
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (s_valid[i] && last_gnt != i) begin
          if ($urandom_range(15, 0) == 0) s_valid[i] = 1'b0;
        end else begin
          s_valid[i] = 1'($urandom);
          s_votes[3*i +: 3] = 3'($urandom);
        end
      end
      s_rready = ($urandom_range(3, 0) != 0);
      s_clr    = ($urandom_range(31, 0) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
